usb_tx_packet_loader_mep: RTL and testbench

Parametrised multi-endpoint successor to the USB TX packet loader. It accepts a packet request for one of NUM_EP endpoints, fetches the payload from a shared packet buffer, and streams PID, payload and CRC16 bytes to the TX bit encoder over a valid/ready handshake. It also tracks a per-endpoint DATA0/DATA1 toggle and supports handshake-only packets (ACK, NAK, STALL).

---
 rtl/usb_tx_pkg.sv | 42 ++++
 rtl/usb_crc16_byte.sv | 21 ++
 rtl/usb_tx_packet_loader_mep.sv | 188 ++++++++++++++++++
 tb/tb_usb_tx_packet_loader_mep.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB TX packet path.
// PID encodings, packet kinds, loader states and CRC16 constants.
package usb_tx_pkg;

    typedef enum logic [1:0] {
        PktData  = 2'd0,
        PktAck   = 2'd1,
        PktNak   = 2'd2,
        PktStall = 2'd3
    } pkt_type_e;

    typedef enum logic [2:0] {
        StIdle,
        StPid,
        StData,
        StCrcLo,
        StCrcHi,
        StDone
    } state_e;

    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_DATA1 = 8'h4B;
    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_NAK   = 8'h5A;
    localparam logic [7:0] PID_STALL = 8'h1E;

    localparam logic [15:0] CRC16_POLY_R     = 16'hA001;
    localparam logic [15:0] CRC16_INIT       = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUAL_R = 16'hB001;

    function automatic logic [7:0] pid_byte(input pkt_type_e t, input logic tog);
        logic [7:0] p;
        case (t)
            PktData: p = tog ? PID_DATA1 : PID_DATA0;
            PktAck:  p = PID_ACK;
            PktNak:  p = PID_NAK;
            default: p = PID_STALL;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/usb_crc16_byte.sv
// Combinational one-byte step of the reflected USB CRC16.
// Shared between the TX loader and the RX checker.
module usb_crc16_byte
    import usb_tx_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data,
    output logic [15:0] crc_out
);

    logic [15:0] c;

    always_comb begin
        c = crc_in ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC16_POLY_R) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/usb_tx_packet_loader_mep.sv
// Multi-endpoint TX packet loader: PID, buffered payload and CRC16 to the bit encoder.
// Keeps a per-endpoint DATA0/DATA1 toggle that is only changed from outside.
module usb_tx_packet_loader_mep
    import usb_tx_pkg::*;
#(
    parameter int unsigned NUM_EP  = 4,
    parameter int unsigned MAX_PKT = 64,
    parameter int unsigned EP_W    = $clog2(NUM_EP),
    parameter int unsigned CNT_W   = $clog2(MAX_PKT + 1),
    parameter int unsigned ADDR_W  = $clog2(NUM_EP * MAX_PKT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [EP_W-1:0]   ep_sel,
    input  logic [1:0]        pkt_type,
    input  logic [CNT_W-1:0]  byte_count,
    input  logic [NUM_EP-1:0] toggle_adv,
    input  logic [NUM_EP-1:0] toggle_clr,
    output logic              buf_rd,
    output logic [ADDR_W-1:0] buf_addr,
    input  logic [7:0]        buf_rdata,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              tx_last,
    output logic              busy,
    output logic              done,
    output logic              err_len,
    output logic [NUM_EP-1:0] toggle_state
);

    state_e            state_q;
    pkt_type_e         type_q;
    logic [EP_W-1:0]   ep_q;
    logic [CNT_W-1:0]  cnt_q, rd_idx_q, tx_idx_q;
    logic              rvalid_q;
    logic [7:0]        hold_q;
    logic              hold_vld_q;
    logic [7:0]        tx_data_q;
    logic              tx_valid_q, tx_last_q, busy_q, done_q, err_len_q;
    logic [15:0]       crc_q, crc_next;
    logic [NUM_EP-1:0] toggle_q;

    logic              fire, fill_phase, rd_issue;
    logic [1:0]        pending;

    usb_crc16_byte u_crc (
        .crc_in  (crc_q),
        .data    (tx_data_q),
        .crc_out (crc_next)
    );

    // A read is only issued when the output register plus the holding register can absorb
    // every byte not yet accepted, so a stalled encoder never overflows the prefetch.
    always_comb begin
        fire       = tx_valid_q && tx_ready;
        fill_phase = (state_q == StPid && type_q == PktData) || state_q == StData;
        pending    = 2'(tx_valid_q && !fire) + 2'(hold_vld_q) + 2'(rvalid_q);
        rd_issue   = fill_phase && (rd_idx_q < cnt_q) && (pending <= 2'd1);
    end

    assign buf_rd       = rd_issue;
    assign buf_addr     = rd_issue ? (ADDR_W'(ep_q) * ADDR_W'(MAX_PKT) + ADDR_W'(rd_idx_q)) : '0;
    assign tx_data      = tx_data_q;
    assign tx_valid     = tx_valid_q;
    assign tx_last      = tx_last_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err_len      = err_len_q;
    assign toggle_state = toggle_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            type_q     <= PktData;
            ep_q       <= '0;
            cnt_q      <= '0;
            rd_idx_q   <= '0;
            tx_idx_q   <= '0;
            rvalid_q   <= 1'b0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            tx_last_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_len_q  <= 1'b0;
            crc_q      <= CRC16_INIT;
            toggle_q   <= '0;
        end else begin
            done_q    <= 1'b0;
            err_len_q <= 1'b0;
            rvalid_q  <= rd_issue;
            if (rd_issue) rd_idx_q <= rd_idx_q + 1'b1;

            for (int i = 0; i < NUM_EP; i++) begin
                if (toggle_clr[i]) toggle_q[i] <= 1'b0;
                else if (toggle_adv[i]) toggle_q[i] <= ~toggle_q[i];
            end

            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        if (pkt_type_e'(pkt_type) == PktData && byte_count > CNT_W'(MAX_PKT)) begin
                            err_len_q <= 1'b1;
                        end else begin
                            ep_q       <= ep_sel;
                            type_q     <= pkt_type_e'(pkt_type);
                            cnt_q      <= byte_count;
                            rd_idx_q   <= '0;
                            tx_idx_q   <= '0;
                            hold_vld_q <= 1'b0;
                            crc_q      <= CRC16_INIT;
                            tx_data_q  <= pid_byte(pkt_type_e'(pkt_type), toggle_q[ep_sel]);
                            tx_valid_q <= 1'b1;
                            tx_last_q  <= (pkt_type_e'(pkt_type) != PktData);
                            busy_q     <= 1'b1;
                            state_q    <= StPid;
                        end
                    end
                end
                StPid, StData: begin
                    if (fire && state_q == StData) begin
                        tx_idx_q <= tx_idx_q + 1'b1;
                        crc_q    <= crc_next;
                    end
                    if (fire && state_q == StPid && type_q != PktData) begin
                        tx_valid_q <= 1'b0;
                        tx_last_q  <= 1'b0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= StDone;
                    end else if (fire && state_q == StPid && cnt_q == '0) begin
                        tx_data_q <= ~crc_q[7:0];
                        tx_last_q <= 1'b0;
                        state_q   <= StCrcLo;
                    end else if (fire && state_q == StData && tx_idx_q == cnt_q - 1'b1) begin
                        tx_data_q <= ~crc_next[7:0];
                        state_q   <= StCrcLo;
                    end else begin
                        if (fire && state_q == StPid) begin
                            tx_last_q <= 1'b0;
                            state_q   <= StData;
                        end
                        // Oldest byte first: holding register, then the byte arriving now.
                        if (!tx_valid_q || fire) begin
                            if (hold_vld_q) begin
                                tx_data_q  <= hold_q;
                                tx_valid_q <= 1'b1;
                                hold_vld_q <= rvalid_q;
                                if (rvalid_q) hold_q <= buf_rdata;
                            end else if (rvalid_q) begin
                                tx_data_q  <= buf_rdata;
                                tx_valid_q <= 1'b1;
                            end else begin
                                tx_valid_q <= 1'b0;
                            end
                        end else if (rvalid_q) begin
                            hold_q     <= buf_rdata;
                            hold_vld_q <= 1'b1;
                        end
                    end
                end
                StCrcLo: begin
                    if (fire) begin
                        tx_data_q <= ~crc_q[15:8];
                        tx_last_q <= 1'b1;
                        state_q   <= StCrcHi;
                    end
                end
                StCrcHi: begin
                    if (fire) begin
                        tx_valid_q <= 1'b0;
                        tx_last_q  <= 1'b0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= StDone;
                    end
                end
                StDone: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_tx_packet_loader_mep.sv
// Directed bench for usb_tx_packet_loader_mep: packet table plus toggle, length and reset cases.
module tb_usb_tx_packet_loader_mep;

    localparam int NUM_EP  = 4;
    localparam int MAX_PKT = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] ep_sel;
    logic [1:0] pkt_type;
    logic [6:0] byte_count;
    logic [3:0] toggle_adv, toggle_clr;
    logic       buf_rd;
    logic [7:0] buf_addr;
    logic [7:0] buf_rdata = 8'h00;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready, tx_last, busy, done, err_len;
    logic [3:0] toggle_state;

    logic use_rand = 1'b0, ready_fixed = 1'b1, rnd_ready = 1'b1;
    assign tx_ready = use_rand ? rnd_ready : ready_fixed;

    usb_tx_packet_loader_mep dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .ep_sel       (ep_sel),
        .pkt_type     (pkt_type),
        .byte_count   (byte_count),
        .toggle_adv   (toggle_adv),
        .toggle_clr   (toggle_clr),
        .buf_rd       (buf_rd),
        .buf_addr     (buf_addr),
        .buf_rdata    (buf_rdata),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx_last      (tx_last),
        .busy         (busy),
        .done         (done),
        .err_len      (err_len),
        .toggle_state (toggle_state)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    always @(posedge clk) if (buf_rd) buf_rdata <= mem[buf_addr];
    always @(posedge clk) begin
        #1 rnd_ready = 1'($urandom_range(0, 1));
    end

    int n_cmp = 0, n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {8'h00, d};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        return r;
    endfunction

    // Monitor: records transfers, reads and done; checks hold-while-stalled.
    logic [7:0] got_q[$];
    logic       last_q[$];
    logic [7:0] addr_q[$];
    int         done_cnt = 0, done_cyc = 0, xfer_cyc = 0;
    logic       stall_prev = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_last = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (stall_prev) begin
                check("stall_valid", 32'(tx_valid), 32'd1);
                check("stall_data", 32'(tx_data), 32'(prev_data));
                check("stall_last", 32'(tx_last), 32'(prev_last));
            end
            if (tx_valid && tx_ready) begin
                got_q.push_back(tx_data);
                last_q.push_back(tx_last);
                xfer_cyc = cyc;
            end
            if (buf_rd) addr_q.push_back(buf_addr);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("busy_at_done", 32'(busy), 32'd0);
            end
            stall_prev = tx_valid && !tx_ready;
        end else begin
            stall_prev = 1'b0;
        end
        prev_data = tx_data;
        prev_last = tx_last;
    end

    task automatic run_pkt(input int ep, input int pt, input int bc, input bit rnd,
                           input logic [7:0] exp_pid);
        logic [7:0]  exp_q[$];
        logic [7:0]  b;
        logic [15:0] c, ci, res;
        int          guard, ones;
        exp_q.delete();
        exp_q.push_back(exp_pid);
        if (pt == 0) begin
            c = 16'hFFFF;
            for (int i = 0; i < bc; i++) begin
                b = mem[ep * MAX_PKT + i];
                exp_q.push_back(b);
                c = crc_upd(c, b);
            end
            ci = ~c;
            exp_q.push_back(ci[7:0]);
            exp_q.push_back(ci[15:8]);
        end
        @(posedge clk); #1;
        got_q.delete(); last_q.delete(); addr_q.delete();
        done_cnt = 0;
        use_rand = rnd;
        start = 1'b1; ep_sel = 2'(ep); pkt_type = 2'(pt); byte_count = 7'(bc);
        @(posedge clk); #1;
        start = 1'b0;
        check("valid_after_start", 32'(tx_valid), 32'd1);
        guard = 0;
        while (done_cnt == 0 && guard < 4000) begin
            @(posedge clk);
            guard++;
        end
        check("done_seen", 32'(done_cnt != 0), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        use_rand = 1'b0;
        check("done_once", 32'(done_cnt), 32'd1);
        check("done_latency", 32'(done_cyc - xfer_cyc), 32'd1);
        check("busy_idle", 32'(busy), 32'd0);
        check("byte_num", 32'(got_q.size()), 32'(exp_q.size()));
        if (got_q.size() == exp_q.size()) begin
            ones = 0;
            for (int i = 0; i < got_q.size(); i++) begin
                check($sformatf("byte%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
                ones += int'(last_q[i]);
            end
            check("last_pos", 32'(last_q[last_q.size() - 1]), 32'd1);
            check("last_cnt", 32'(ones), 32'd1);
            if (pt == 0) begin
                res = 16'hFFFF;
                for (int i = 1; i < got_q.size(); i++) res = crc_upd(res, got_q[i]);
                check("crc_residual", 32'(res), 32'hB001);
            end
        end
        check("rd_num", 32'(addr_q.size()), 32'((pt == 0) ? bc : 0));
        if (pt == 0 && addr_q.size() == bc) begin
            for (int i = 0; i < bc; i++) check($sformatf("addr%0d", i), 32'(addr_q[i]), 32'(ep * MAX_PKT + i));
        end
    endtask

    typedef struct {
        int         ep;
        int         pt;
        int         bc;
        bit         rnd;
        logic [7:0] pid;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{ep: 2, pt: 1, bc: 0,  rnd: 1'b0, pid: 8'hD2};
        vecs[1] = '{ep: 3, pt: 2, bc: 5,  rnd: 1'b0, pid: 8'h5A};
        vecs[2] = '{ep: 0, pt: 3, bc: 0,  rnd: 1'b1, pid: 8'h1E};
        vecs[3] = '{ep: 0, pt: 0, bc: 0,  rnd: 1'b0, pid: 8'hC3};
        vecs[4] = '{ep: 1, pt: 0, bc: 4,  rnd: 1'b0, pid: 8'hC3};
        vecs[5] = '{ep: 1, pt: 0, bc: 4,  rnd: 1'b1, pid: 8'hC3};
        vecs[6] = '{ep: 3, pt: 0, bc: 64, rnd: 1'b0, pid: 8'hC3};
        vecs[7] = '{ep: 2, pt: 0, bc: 1,  rnd: 1'b1, pid: 8'hC3};

        // EP1 slot holds 00 01 02 03 ...
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h40;

        rst = 1'b1; start = 1'b0; ep_sel = '0; pkt_type = '0; byte_count = '0;
        toggle_adv = '0; toggle_clr = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(tx_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_flags", 32'({done, err_len, buf_rd, tx_last}), 32'd0);
        check("rst_data_addr", 32'({tx_data, buf_addr}), 32'd0);
        check("rst_toggle", 32'(toggle_state), 32'd0);
        rst = 1'b0;

        for (int v = 0; v < 8; v++) run_pkt(vecs[v].ep, vecs[v].pt, vecs[v].bc, vecs[v].rnd, vecs[v].pid);

        // Toggle advance selects DATA1; loader leaves the toggle alone.
        @(posedge clk); #1; toggle_adv = 4'b0010;
        @(posedge clk); #1; toggle_adv = 4'b0000;
        check("toggle_adv", 32'(toggle_state), 32'b0010);
        run_pkt(1, 0, 4, 1'b0, 8'h4B);
        check("toggle_kept", 32'(toggle_state), 32'b0010);
        @(posedge clk); #1; toggle_adv = 4'b0010; toggle_clr = 4'b0010;
        @(posedge clk); #1; toggle_adv = 4'b0000; toggle_clr = 4'b0000;
        check("clr_wins", 32'(toggle_state), 32'b0000);

        // Over-length DATA request.
        @(posedge clk); #1;
        start = 1'b1; ep_sel = 2'd1; pkt_type = 2'd0; byte_count = 7'd65;
        @(posedge clk); #1;
        start = 1'b0;
        check("err_len_pulse", 32'(err_len), 32'd1);
        check("err_no_valid", 32'(tx_valid), 32'd0);
        check("err_no_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check("err_len_once", 32'(err_len), 32'd0);
        check("err_still_idle", 32'({tx_valid, busy, buf_rd}), 32'd0);

        // Reset in the middle of a long payload.
        toggle_adv = 4'b0100;
        @(posedge clk); #1; toggle_adv = 4'b0000;
        check("toggle_pre_rst", 32'(toggle_state), 32'b0100);
        start = 1'b1; ep_sel = 2'd1; pkt_type = 2'd0; byte_count = 7'd64;
        @(posedge clk); #1; start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_valid", 32'(tx_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_toggle", 32'(toggle_state), 32'd0);
        check("mid_rst_rd", 32'(buf_rd), 32'd0);
        rst = 1'b0;
        run_pkt(2, 1, 0, 1'b0, 8'hD2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
